// File: rtl/fmc_cfg_pkg.sv
// Shared address map and FSM state types for the FMC frequency configuration controller.
package fmc_cfg_pkg;

    localparam logic [11:0] ADDR_CH1_FREQ_B0 = 12'h003;
    localparam logic [11:0] ADDR_CH2_FREQ_B0 = 12'h103;
    localparam logic [11:0] ADDR_CH1_EN      = 12'h02D;
    localparam logic [11:0] ADDR_CH2_EN      = 12'h12D;
    localparam logic [11:0] ADDR_SYNC_RST    = 12'h204;
    localparam logic [11:0] CH_OFFSET        = 12'h100;
    localparam int unsigned FREQ_BYTES       = 6;

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } stage_state_e;

    typedef enum logic {
        SYNC_IDLE,
        SYNC_ACTIVE
    } sync_state_e;

    function automatic logic in_freq_range(input logic [11:0] addr, input logic [11:0] base);
        return (addr >= base) && (addr < base + 12'(FREQ_BYTES));
    endfunction

endpackage

// File: rtl/freq_word_stager.sv
// Per-channel tuning-word stager: byte-wise shadow, PEND FSM with timeout, atomic commit to active word.
module freq_word_stager
    import fmc_cfg_pkg::*;
#(
    parameter int unsigned COMMIT_TIMEOUT = 1024,
    parameter int unsigned FW             = 48
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          byte_wr_i,
    input  logic [2:0]    byte_sel_i,
    input  logic [7:0]    wdata_i,
    input  logic          boundary_i,
    input  logic          sync_commit_i,
    input  logic          sync_hold_i,
    output logic [FW-1:0] active_word_o,
    output logic          upd_o,
    output logic          pending_o
);

    localparam int unsigned     TW         = $clog2(COMMIT_TIMEOUT);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(COMMIT_TIMEOUT - 1);
    localparam logic [2:0]      MSB_SEL    = 3'(FW / 8 - 1);

    stage_state_e  state_q, state_d;
    logic [FW-1:0] shadow_q, shadow_d;
    logic [FW-1:0] active_q, active_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          upd_q, upd_d;
    logic          msb_wr;
    logic          commit_now;

    assign msb_wr = byte_wr_i && (byte_sel_i == MSB_SEL);

    // An MSB write in the same cycle as a boundary defers the commit to a later boundary.
    assign commit_now = (state_q == ST_PEND) && !msb_wr && !sync_hold_i &&
                        (boundary_i || (timer_q == TIMER_LAST));

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        timer_d  = timer_q;
        upd_d    = 1'b0;

        if (byte_wr_i) begin
            for (int unsigned b = 0; b < FW / 8; b++) begin
                if (byte_sel_i == 3'(b)) shadow_d[8*b +: 8] = wdata_i;
            end
        end

        if ((state_q == ST_PEND) && (timer_q != TIMER_LAST)) timer_d = timer_q + 1'b1;

        if (sync_commit_i || commit_now) begin
            active_d = shadow_q;
            upd_d    = 1'b1;
            state_d  = ST_IDLE;
            timer_d  = '0;
        end

        // MSB write re-arms pending even when a sync commit takes the older shadow.
        if (msb_wr) begin
            state_d = ST_PEND;
            timer_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            active_q <= '0;
            timer_q  <= '0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            timer_q  <= timer_d;
            upd_q    <= upd_d;
        end
    end

    assign active_word_o = active_q;
    assign upd_o         = upd_q;
    assign pending_o     = (state_q == ST_PEND);

endmodule

// File: rtl/fmc_freq_cfg_ctrl.sv
// FMC register decode, two-channel tuning-word staging and global sync-reset control.
// Optional readback port enabled by defining FREQ_READBACK_EN.
module fmc_freq_cfg_ctrl
    import fmc_cfg_pkg::*;
#(
    parameter int unsigned COMMIT_TIMEOUT = 1024,
    parameter int unsigned SYNC_PULSE_LEN = 4,
    parameter int unsigned FW             = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          reg_wr,
    input  logic [11:0]   reg_addr,
    input  logic [7:0]    reg_wdata,
    input  logic [1:0]    ch_boundary,
    output logic [FW-1:0] ch1_freq_word,
    output logic [FW-1:0] ch2_freq_word,
    output logic [1:0]    freq_upd,
    output logic [1:0]    ch_en,
    output logic          phase_rst,
    output logic          busy
`ifdef FREQ_READBACK_EN
    ,
    input  logic [11:0]   rd_addr,
    output logic [7:0]    rd_data
`endif
);

    localparam int unsigned SW        = (SYNC_PULSE_LEN > 1) ? $clog2(SYNC_PULSE_LEN) : 1;
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_PULSE_LEN - 1);

    logic          ch1_hit, ch2_hit, sync_wr, sync_hold;
    logic [2:0]    ch1_sel, ch2_sel;
    logic [1:0]    pending;
    logic [1:0]    ch_en_q;
    logic          busy_q;
    sync_state_e   sync_state_q, sync_state_d;
    logic [SW-1:0] sync_cnt_q, sync_cnt_d;

    assign ch1_hit   = reg_wr && in_freq_range(reg_addr, ADDR_CH1_FREQ_B0);
    assign ch2_hit   = reg_wr && in_freq_range(reg_addr, ADDR_CH1_FREQ_B0 + CH_OFFSET);
    assign ch1_sel   = 3'(reg_addr - ADDR_CH1_FREQ_B0);
    assign ch2_sel   = 3'(reg_addr - ADDR_CH2_FREQ_B0);
    assign sync_wr   = reg_wr && (reg_addr == ADDR_SYNC_RST) && reg_wdata[0];
    assign sync_hold = (sync_state_q == SYNC_ACTIVE);

    freq_word_stager #(.COMMIT_TIMEOUT(COMMIT_TIMEOUT), .FW(FW)) u_stage_ch1 (
        .clk_i(clk), .rst_ni(rst_n), .byte_wr_i(ch1_hit), .byte_sel_i(ch1_sel),
        .wdata_i(reg_wdata), .boundary_i(ch_boundary[0]), .sync_commit_i(sync_wr),
        .sync_hold_i(sync_hold), .active_word_o(ch1_freq_word), .upd_o(freq_upd[0]),
        .pending_o(pending[0])
    );

    freq_word_stager #(.COMMIT_TIMEOUT(COMMIT_TIMEOUT), .FW(FW)) u_stage_ch2 (
        .clk_i(clk), .rst_ni(rst_n), .byte_wr_i(ch2_hit), .byte_sel_i(ch2_sel),
        .wdata_i(reg_wdata), .boundary_i(ch_boundary[1]), .sync_commit_i(sync_wr),
        .sync_hold_i(sync_hold), .active_word_o(ch2_freq_word), .upd_o(freq_upd[1]),
        .pending_o(pending[1])
    );

    // A repeated sync write while active restarts the pulse count.
    always_comb begin
        sync_state_d = sync_state_q;
        sync_cnt_d   = sync_cnt_q;
        case (sync_state_q)
            SYNC_IDLE:   ;
            SYNC_ACTIVE: begin
                if (sync_cnt_q == SYNC_LAST) sync_state_d = SYNC_IDLE;
                else                         sync_cnt_d   = sync_cnt_q + 1'b1;
            end
            default:     sync_state_d = SYNC_IDLE;
        endcase
        if (sync_wr) begin
            sync_state_d = SYNC_ACTIVE;
            sync_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_state_q <= SYNC_IDLE;
            sync_cnt_q   <= '0;
            ch_en_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            sync_state_q <= sync_state_d;
            sync_cnt_q   <= sync_cnt_d;
            busy_q       <= (|pending) || sync_hold;
            if (reg_wr && (reg_addr == ADDR_CH1_EN)) ch_en_q[0] <= reg_wdata[0];
            if (reg_wr && (reg_addr == ADDR_CH2_EN)) ch_en_q[1] <= reg_wdata[0];
        end
    end

    assign ch_en     = ch_en_q;
    assign phase_rst = sync_hold;
    assign busy      = busy_q;

`ifdef FREQ_READBACK_EN
    logic [7:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        for (int unsigned b = 0; b < FW / 8; b++) begin
            if (rd_addr == ADDR_CH1_FREQ_B0 + 12'(b)) rd_data_d = ch1_freq_word[8*b +: 8];
            if (rd_addr == ADDR_CH2_FREQ_B0 + 12'(b)) rd_data_d = ch2_freq_word[8*b +: 8];
        end
        if (rd_addr == ADDR_CH1_EN) rd_data_d = {7'b0, ch_en_q[0]};
        if (rd_addr == ADDR_CH2_EN) rd_data_d = {7'b0, ch_en_q[1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_fmc_freq_cfg_ctrl.sv
// Scoreboard bench for fmc_freq_cfg_ctrl: stimulus pushes expected commits, a negedge monitor checks them.
module tb_fmc_freq_cfg_ctrl;

    localparam int unsigned CT = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_wr = 1'b0;
    logic [11:0] reg_addr = '0;
    logic [7:0]  reg_wdata = '0;
    logic [1:0]  ch_boundary = '0;
    logic [47:0] ch1_freq_word, ch2_freq_word;
    logic [1:0]  freq_upd, ch_en;
    logic        phase_rst, busy;
`ifdef FREQ_READBACK_EN
    logic [11:0] rd_addr = '0;
    logic [7:0]  rd_data;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        int          at;
        logic [1:0]  upd;
        logic [47:0] w1;
        logic [47:0] w2;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    fmc_freq_cfg_ctrl #(.COMMIT_TIMEOUT(CT), .SYNC_PULSE_LEN(4), .FW(48)) dut (
        .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .ch_boundary(ch_boundary),
        .ch1_freq_word(ch1_freq_word), .ch2_freq_word(ch2_freq_word),
        .freq_upd(freq_upd), .ch_en(ch_en), .phase_rst(phase_rst), .busy(busy)
`ifdef FREQ_READBACK_EN
        , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wr    = 1'b1;
        tick();
        reg_wr    = 1'b0;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_commit(input int at, input logic [1:0] upd,
                                 input logic [47:0] w1, input logic [47:0] w2);
        q.push_back('{at: at, upd: upd, w1: w1, w2: w2});
    endtask

    always @(negedge clk) begin
        if (mon_en && (freq_upd !== 2'b00)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL commit_unexpected: got upd=%b w1=%0h w2=%0h at cyc %0d, want no commit",
                         freq_upd, ch1_freq_word, ch2_freq_word, cyc);
            end else begin
                mon_e = q.pop_front();
                if (cyc !== mon_e.at || freq_upd !== mon_e.upd ||
                    ch1_freq_word !== mon_e.w1 || ch2_freq_word !== mon_e.w2) begin
                    bad++;
                    $display("FAIL commit: got cyc=%0d upd=%b w1=%0h w2=%0h want cyc=%0d upd=%b w1=%0h w2=%0h",
                             cyc, freq_upd, ch1_freq_word, ch2_freq_word,
                             mon_e.at, mon_e.upd, mon_e.w1, mon_e.w2);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        logic [47:0] w, w1x, w2x;
        int n;
        w = 48'd9007199254740;

        // reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_words", {ch1_freq_word, ch2_freq_word}, '0);
        chk("reset_ctrl", {freq_upd, ch_en, phase_rst, busy}, '0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // 1: byte writes then boundary commit on CH1
        for (int unsigned b = 0; b < 6; b++) wr(12'h003 + 12'(b), w[8*b +: 8]);
        chk("t1_word_held", ch1_freq_word, '0);
        tick();
        chk("t1_busy", busy, 1);
        ch_boundary = 2'b01;
        expect_commit(cyc + 1, 2'b01, w, '0);
        tick();
        ch_boundary = 2'b00;
        repeat (2) tick();

        // 2: timeout commit on CH2
        n = cyc;
        wr(12'h108, 8'hAB);
        expect_commit(n + 1 + CT, 2'b10, w, {8'hAB, 40'h0});
        repeat (CT) tick();
        chk("t2_busy_at_commit", busy, 1);
        tick();
        chk("t2_busy_after", busy, 0);

        // 3: sync commit of both shadows, phase_rst width
        for (int unsigned b = 0; b < 6; b++) begin
            wr(12'h003 + 12'(b), w[8*b +: 8]);
            wr(12'h103 + 12'(b), w[8*b +: 8]);
        end
        n = cyc;
        wr(12'h204, 8'h0F);
        expect_commit(n + 1, 2'b11, w, w);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_phase_rst_%0d", i), phase_rst, 1);
            tick();
        end
        chk("t3_phase_rst_fall", phase_rst, 0);
        tick();
        chk("t3_busy_clear", busy, 0);

        // 4: ignored sync, channel enables
        wr(12'h204, 8'h0E);
        chk("t4_no_sync", {phase_rst, busy}, 0);
        wr(12'h02D, 8'h0F);
        wr(12'h12D, 8'h01);
        chk("t4_en_both", ch_en, 2'b11);
        wr(12'h12D, 8'h00);
        chk("t4_en_ch1", ch_en, 2'b01);

        // 5: MSB write coincident with boundary defers commit
        wr(12'h003, 8'h11);
        wr(12'h008, 8'h33);
        ch_boundary = 2'b01;
        wr(12'h008, 8'h44);
        ch_boundary = 2'b00;
        repeat (3) tick();
        w1x = w;
        w1x[7:0]   = 8'h11;
        w1x[47:40] = 8'h44;
        ch_boundary = 2'b01;
        expect_commit(cyc + 1, 2'b01, w1x, w);
        tick();
        ch_boundary = 2'b00;
        repeat (2) tick();

        // 6: reset while pending and phase_rst high
        wr(12'h108, 8'h55);
        w2x = w;
        w2x[47:40] = 8'h55;
        n = cyc;
        wr(12'h204, 8'h01);
        expect_commit(n + 1, 2'b11, w1x, w2x);
        wr(12'h108, 8'h66);
        chk("t6_phase_rst_pre", phase_rst, 1);
        rst_n = 1'b0;
        tick();
        chk("t6_reset_words", {ch1_freq_word, ch2_freq_word}, '0);
        chk("t6_reset_ctrl", {freq_upd, ch_en, phase_rst, busy}, '0);
        rst_n = 1'b1;
        tick();
        ch_boundary = 2'b11;
        tick();
        ch_boundary = 2'b00;
        repeat (CT + 50) tick();
        chk("t6_no_commit_words", {ch1_freq_word, ch2_freq_word}, '0);
        chk("t6_idle_busy", busy, 0);

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
